heading_smoother: RTL and testbench

Slew-limited heading tracker that sits directly downstream of the x/y-to-angle approximation stage. On each `sample_in` strobe it waits out the angle stage's fixed pipeline latency and captures the 0–359° angle. It then moves its own heading toward that angle by at most `MAX_STEP` degrees, taking the shortest way around the circle. The smoothed heading and a sprite sector index feed the car renderer.

---
 rtl/heading_smoother.sv | 142 ++++++++++++++
 tb/tb_heading_smoother.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/heading_smoother.sv
// Slew-limited heading tracker: captures the angle stage result and steps toward it the short way round.
// Latency: outputs and valid_out appear ANGLE_LATENCY+1 cycles after the sample_in edge.
// No backpressure: sample_in is dropped while busy_out is high, nothing is queued.
module heading_smoother #(
    parameter int ANGLE_LATENCY = 37,
    parameter int MAX_STEP      = 8,
    parameter int DEADBAND      = 2,
    parameter int SECTOR_DEG    = 15
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               sample_in,
    input  logic signed [31:0] angle_in,
    output logic        [8:0]  heading_out,
    output logic        [4:0]  sector_out,
    output logic        [1:0]  dir_out,
    output logic               valid_out,
    output logic               busy_out
);

    localparam int CW = $clog2(ANGLE_LATENCY + 1);
    localparam logic signed [10:0] S180  = 11'sd180;
    localparam logic signed [10:0] S360  = 11'sd360;
    localparam logic signed [10:0] MAX_S = 11'(MAX_STEP);
    localparam logic signed [10:0] DB_S  = 11'(DEADBAND);

    typedef enum logic [1:0] {IDLE, WAIT, UPDATE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic signed [31:0] target_q, target_d;
    logic               snapped_q, snapped_d;
    logic [8:0]         heading_d;
    logic [4:0]         sector_d;
    logic [1:0]         dir_d;
    logic               valid_d;

    logic               in_range;
    logic signed [10:0] err_raw, err_w, err_abs, step, sum;
    logic [8:0]         stepped;
    logic [1:0]         step_dir;

    // Shortest-path error, deadband, clamp and single-step wrap.
    always_comb begin
        in_range = (target_q >= 32'sd0) && (target_q <= 32'sd359);
        err_raw  = $signed({2'b00, target_q[8:0]}) - $signed({2'b00, heading_out});
        err_w    = err_raw;
        if (err_raw > S180)
            err_w = err_raw - S360;
        else if (err_raw <= -S180)
            err_w = err_raw + S360;
        err_abs = (err_w < 11'sd0) ? -err_w : err_w;
        if (err_abs <= DB_S)
            step = 11'sd0;
        else if (err_w > MAX_S)
            step = MAX_S;
        else if (err_w < -MAX_S)
            step = -MAX_S;
        else
            step = err_w;
        sum = $signed({2'b00, heading_out}) + step;
        if (sum < 11'sd0)
            sum = sum + S360;
        else if (sum >= S360)
            sum = sum - S360;
        stepped = sum[8:0];
        if (step > 11'sd0)
            step_dir = 2'b01;
        else if (step < 11'sd0)
            step_dir = 2'b10;
        else
            step_dir = 2'b00;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        snapped_d = snapped_q;
        heading_d = heading_out;
        dir_d     = dir_out;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_in && !valid_out) begin
                    state_d = WAIT;
                    cnt_d   = CW'(ANGLE_LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    target_d = angle_in;
                    state_d  = UPDATE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            UPDATE: begin
                state_d = IDLE;
                if (in_range) begin
                    valid_d = 1'b1;
                    if (!snapped_q) begin
                        heading_d = target_q[8:0];
                        dir_d     = 2'b00;
                        snapped_d = 1'b1;
                    end else begin
                        heading_d = stepped;
                        dir_d     = step_dir;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        sector_d = 5'(heading_d / 9'(SECTOR_DEG));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            target_q    <= '0;
            snapped_q   <= 1'b0;
            heading_out <= '0;
            sector_out  <= '0;
            dir_out     <= 2'b00;
            valid_out   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            snapped_q   <= snapped_d;
            heading_out <= heading_d;
            sector_out  <= sector_d;
            dir_out     <= dir_d;
            valid_out   <= valid_d;
        end
    end

    // Held through the valid_out cycle so the next sample lands strictly after it.
    assign busy_out = (state_q != IDLE) || valid_out;

endmodule

// File: tb/tb_heading_smoother.sv
// Directed table-driven bench for heading_smoother.
module tb_heading_smoother;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b0;
    logic               sample_in = 1'b0;
    logic signed [31:0] angle_in = 32'sd999;
    logic [8:0]         heading_out;
    logic [4:0]         sector_out;
    logic [1:0]         dir_out;
    logic               valid_out;
    logic               busy_out;

    heading_smoother dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .sample_in   (sample_in),
        .angle_in    (angle_in),
        .heading_out (heading_out),
        .sector_out  (sector_out),
        .dir_out     (dir_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int failed = 0;
    int vcnt = 0;

    always @(posedge clk_in) if (valid_out) vcnt <= vcnt + 1;

    // mode 0: plain sample, 1: extra sample_in pulses mid-wait, 2: reset mid-wait
    typedef struct {
        bit rst_first;
        int ang;
        int mode;
        bit ev;
        int eh;
        int es;
        int ed;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        sample_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic run(input int idx, input vec_t v);
        int  v0;
        bit  busy_bad;
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (v.rst_first) do_reset();
        v0 = vcnt;
        busy_bad = 1'b0;
        @(negedge clk_in);
        sample_in = 1'b1;
        angle_in = 32'sd999;
        @(posedge clk_in);
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk_in);
            sample_in = (v.mode == 1) && (c == 5 || c == 20);
            angle_in = (c == 37) ? v.ang : 32'sd999;
            if (v.mode == 2 && c == 20) rst_in = 1'b0;
            if (v.mode == 2 && c == 21) rst_in = 1'b1;
            if ((v.mode != 2 || c <= 20) && !busy_out) busy_bad = 1'b1;
            @(posedge clk_in);
        end
        #1;
        sample_in = 1'b0;
        chk({tag, " busy_during"}, int'(busy_bad), 0);
        chk({tag, " heading"}, int'(heading_out), v.eh);
        chk({tag, " sector"}, int'(sector_out), v.es);
        chk({tag, " dir"}, int'(dir_out), v.ed);
        chk({tag, " valid"}, int'(valid_out), int'(v.ev));
        chk({tag, " busy_at_update"}, int'(busy_out), int'(v.ev));
        @(posedge clk_in);
        #1;
        chk({tag, " valid_after"}, int'(valid_out), 0);
        chk({tag, " busy_after"}, int'(busy_out), 0);
        chk({tag, " valid_count"}, vcnt - v0, int'(v.ev));
    endtask

    initial begin
        vecs.push_back('{1, 40,  0, 1, 40,  2, 0});
        vecs.push_back('{0, 100, 0, 1, 48,  3, 1});
        vecs.push_back('{0, 100, 0, 1, 56,  3, 1});
        vecs.push_back('{0, 100, 0, 1, 64,  4, 1});
        vecs.push_back('{0, 100, 0, 1, 72,  4, 1});
        vecs.push_back('{0, 100, 0, 1, 80,  5, 1});
        vecs.push_back('{0, 100, 0, 1, 88,  5, 1});
        vecs.push_back('{0, 100, 0, 1, 96,  6, 1});
        vecs.push_back('{0, 100, 0, 1, 100, 6, 1});
        vecs.push_back('{0, 100, 0, 1, 100, 6, 0});
        vecs.push_back('{0, 102, 0, 1, 100, 6, 0});
        vecs.push_back('{0, 110, 0, 1, 108, 7, 1});
        vecs.push_back('{0, 400, 0, 0, 108, 7, 1});
        vecs.push_back('{0, -5,  0, 0, 108, 7, 1});
        vecs.push_back('{1, 356, 0, 1, 356, 23, 0});
        vecs.push_back('{0, 10,  0, 1, 4,   0, 1});
        vecs.push_back('{1, 5,   0, 1, 5,   0, 0});
        vecs.push_back('{0, 350, 0, 1, 357, 23, 2});
        vecs.push_back('{1, 0,   0, 1, 0,   0, 0});
        vecs.push_back('{0, 180, 0, 1, 8,   0, 1});
        vecs.push_back('{1, 180, 0, 1, 180, 12, 0});
        vecs.push_back('{0, 0,   0, 1, 188, 12, 1});
        vecs.push_back('{0, 150, 1, 1, 180, 12, 2});
        vecs.push_back('{0, 77,  2, 0, 0,   0, 0});
        vecs.push_back('{0, 200, 0, 1, 200, 13, 0});
        vecs.push_back('{0, 197, 0, 1, 197, 13, 2});
        vecs.push_back('{0, 195, 0, 1, 197, 13, 0});

        do_reset();
        #1;
        chk("reset heading", int'(heading_out), 0);
        chk("reset sector", int'(sector_out), 0);
        chk("reset dir", int'(dir_out), 0);
        chk("reset valid", int'(valid_out), 0);
        chk("reset busy", int'(busy_out), 0);

        for (int i = 0; i < vecs.size(); i++) run(i, vecs[i]);

        // Idle stretch: outputs must hold with no sample in flight.
        repeat (10) @(posedge clk_in);
        #1;
        chk("hold heading", int'(heading_out), 197);
        chk("hold valid", int'(valid_out), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
